// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: definitions shared by the ALU control issue stage.
//   - 3-bit ALU control encodings
//   - MIPS opcode / funct values recognised by the decoder
//   - bit layout of the decoded word held in the skid buffer:
//       [0] illegal, [1] ov_trap, [2] alu_src_imm, [5:3] alu_ctrl, [DW+5:6] ext_imm
//   - skid buffer occupancy states
package alu_ctrl_pkg;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_SLT  = 3'b011;
   localparam logic [2:0] ALU_ADD  = 3'b100;
   localparam logic [2:0] ALU_ADDU = 3'b101;
   localparam logic [2:0] ALU_SUB  = 3'b110;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   localparam int DEC_ILL_BIT  = 0;
   localparam int DEC_OV_BIT   = 1;
   localparam int DEC_SRC_BIT  = 2;
   localparam int DEC_CTRL_LSB = 3;
   localparam int DEC_CTRL_W   = 3;
   localparam int DEC_IMM_LSB  = 6;

   // Total decoded-word width for a given operand width.
   function automatic int dec_width(input int dw);
      return dw + DEC_IMM_LSB;
   endfunction

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: pure combinational MIPS instruction -> ALU control word.
// Ports:
//   instr  in   32             fetched instruction word
//   dec    out  dec_width(DW)  {ext_imm, alu_ctrl, alu_src_imm, ov_trap, illegal}
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [31:0]            instr,
   output logic [dec_width(DW)-1:0] dec
);

   logic [5:0]    op;
   logic [5:0]    funct;
   logic [15:0]   imm;
   logic [2:0]    ctrl;
   logic          src_imm;
   logic          ov;
   logic          ill;
   logic          zext;
   logic [DW-1:0] ext;
   logic          unused_fields;

   assign op    = instr[31:26];
   assign funct = instr[5:0];
   assign imm   = instr[15:0];
   // Register specifiers are consumed by the register file, not here.
   assign unused_fields = ^instr[25:16];

   always_comb begin
      ctrl    = ALU_AND;
      src_imm = 1'b0;
      ov      = 1'b0;
      ill     = 1'b0;
      zext    = 1'b0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:          begin ctrl = ALU_ADD;  ov = 1'b1; end
               FN_ADDU:         ctrl = ALU_ADDU;
               FN_SUB:          begin ctrl = ALU_SUB;  ov = 1'b1; end
               FN_SUBU:         ctrl = ALU_SUB;
               FN_AND:          ctrl = ALU_AND;
               FN_OR:           ctrl = ALU_OR;
               FN_SLT, FN_SLTU: ctrl = ALU_SLT;
               default:         ill  = 1'b1;
            endcase
         end
         OP_ADDI:       begin ctrl = ALU_ADD;  src_imm = 1'b1; ov = 1'b1; end
         OP_ADDIU:      begin ctrl = ALU_ADDU; src_imm = 1'b1; end
         OP_SLTI:       begin ctrl = ALU_SLT;  src_imm = 1'b1; end
         OP_ANDI:       begin ctrl = ALU_AND;  src_imm = 1'b1; zext = 1'b1; end
         OP_ORI:        begin ctrl = ALU_OR;   src_imm = 1'b1; zext = 1'b1; end
         OP_LW, OP_SW:  begin ctrl = ALU_ADDU; src_imm = 1'b1; end
         // Branches compare rs against rt, so B comes from the register file.
         OP_BEQ, OP_BNE: ctrl = ALU_SUB;
         default:       ill = 1'b1;
      endcase
      // Illegal decode leaves every control at its safe default above.
      ext = zext ? {{(DW-16){1'b0}}, imm} : {{(DW-16){imm[15]}}, imm};
      dec = {ext, ctrl, src_imm, ov, ill};
   end

endmodule

// File: rtl/alu_ctrl_issue.sv
// alu_ctrl_issue: decodes MIPS instructions into ALU control words and
// issues them through a 2-entry skid buffer (valid/ready on both sides).
// Optional feature macro: ALU_ILLEGAL_TRAP_EN
//   defined   - illegal instructions are buffered and delivered with illegal=1
//   undefined - illegal instructions are accepted and dropped; illegal tied 0
// Ports:
//   clk, rst_n (async, active-low)
//   in_valid/in_ready/in_instr   upstream handshake, in_ready registered
//   flush                        discard all buffered entries
//   out_valid/out_ready          downstream handshake
//   alu_ctrl, alu_src_imm, ext_imm, ov_trap, illegal   head entry fields
module alu_ctrl_issue
   import alu_ctrl_pkg::*;
#(
   parameter int DW    = 32,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_instr,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [2:0]    alu_ctrl,
   output logic          alu_src_imm,
   output logic [DW-1:0] ext_imm,
   output logic          ov_trap,
   output logic          illegal
);

   localparam int WW = dec_width(DW);

   generate
      if (DEPTH != 2) begin : g_depth_err
         $error("alu_ctrl_issue: DEPTH must be 2");
      end
   endgenerate

   skid_state_t   state, state_next;
   logic [WW-1:0] dec_word;
   logic [WW-1:0] head, tail;
   logic          in_ready_q;
   logic          push, pop, store;
   logic          load_head, load_tail, move_tail;

   alu_ctrl_decode #(.DW(DW)) u_decode (
      .instr (in_instr),
      .dec   (dec_word)
   );

   assign push = in_valid & in_ready_q;
   assign pop  = out_valid & out_ready;

`ifdef ALU_ILLEGAL_TRAP_EN
   assign store = push;
`else
   // Illegal words complete the input handshake but never occupy an entry.
   assign store = push & ~dec_word[DEC_ILL_BIT];
`endif

   always_comb begin
      state_next = state;
      load_head  = 1'b0;
      load_tail  = 1'b0;
      move_tail  = 1'b0;
      if (flush) begin
         state_next = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (store) begin
                  state_next = ST_ONE;
                  load_head  = 1'b1;
               end
            end
            ST_ONE: begin
               if (store && !pop) begin
                  state_next = ST_TWO;
                  load_tail  = 1'b1;
               end else if (pop && !store) begin
                  state_next = ST_EMPTY;
               end else if (store && pop) begin
                  load_head  = 1'b1;
               end
            end
            ST_TWO: begin
               // in_ready is low here, so only a pop can happen.
               if (pop) begin
                  state_next = ST_ONE;
                  move_tail  = 1'b1;
               end
            end
            default: state_next = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_EMPTY;
         in_ready_q <= 1'b0;
         head       <= '0;
         tail       <= '0;
      end else begin
         state      <= state_next;
         in_ready_q <= (state_next != ST_TWO);
         if (load_head)      head <= dec_word;
         else if (move_tail) head <= tail;
         if (load_tail)      tail <= dec_word;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = (state != ST_EMPTY);
   assign alu_ctrl    = head[DEC_CTRL_LSB +: DEC_CTRL_W];
   assign alu_src_imm = head[DEC_SRC_BIT];
   assign ext_imm     = head[DEC_IMM_LSB +: DW];
   assign ov_trap     = head[DEC_OV_BIT];

`ifdef ALU_ILLEGAL_TRAP_EN
   assign illegal = head[DEC_ILL_BIT];
`else
   logic unused_ill;
   assign unused_ill = head[DEC_ILL_BIT];
   assign illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Directed testbench for alu_ctrl_issue: reset, streaming, immediates,
// backpressure, flush and illegal-instruction handling.
module tb_alu_ctrl_issue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  alu_ctrl;
   logic        alu_src_imm;
   logic [31:0] ext_imm;
   logic        ov_trap;
   logic        illegal;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   alu_ctrl_issue #(.DW(32), .DEPTH(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .alu_ctrl    (alu_ctrl),
      .alu_src_imm (alu_src_imm),
      .ext_imm     (ext_imm),
      .ov_trap     (ov_trap),
      .illegal     (illegal)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic check_word(input string tag, input logic [2:0] ctrl, input logic src,
                             input logic [31:0] imm, input logic ov);
      check({tag, ".valid"}, 64'(out_valid), 64'd1);
      check({tag, ".ctrl"},  64'(alu_ctrl), 64'(ctrl));
      check({tag, ".src"},   64'(alu_src_imm), 64'(src));
      check({tag, ".imm"},   64'(ext_imm), 64'(imm));
      check({tag, ".ov"},    64'(ov_trap), 64'(ov));
      check({tag, ".ill"},   64'(illegal), 64'd0);
      $display("txn %s: ctrl=%b src=%b imm=%08h ov=%b", tag, alu_ctrl, alu_src_imm, ext_imm, ov_trap);
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Streaming table: add, sub, andi 0x00F0, ori 0x1234, slti 0x8000, lw 4
   logic [31:0] s_instr [6] = '{32'h00221820, 32'h00221822, 32'h302200F0,
                                32'h34221234, 32'h28228000, 32'h8C220004};
   logic [2:0]  s_ctrl  [6] = '{3'b100, 3'b110, 3'b000, 3'b001, 3'b011, 3'b101};
   logic        s_src   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   logic [31:0] s_imm   [6] = '{32'h00001820, 32'h00001822, 32'h000000F0,
                                32'h00001234, 32'hFFFF8000, 32'h00000004};
   logic        s_ov    [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   // Immediates table: andi 0xFFFF, addi 0xFFFF, beq offset 3
   logic [31:0] i_instr [3] = '{32'h3022FFFF, 32'h2022FFFF, 32'h10220003};
   logic [2:0]  i_ctrl  [3] = '{3'b000, 3'b100, 3'b110};
   logic        i_src   [3] = '{1'b1, 1'b1, 1'b0};
   logic [31:0] i_imm   [3] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h00000003};
   logic        i_ov    [3] = '{1'b0, 1'b1, 1'b0};

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = 32'h0;
      flush     = 1'b0;
      out_ready = 1'b0;

      // ---- Reset and release ----
      step();
      step();
      check("rst.in_ready",  64'(in_ready), 64'd0);
      check("rst.out_valid", 64'(out_valid), 64'd0);
      check("rst.ctrl",      64'(alu_ctrl), 64'd0);
      check("rst.imm",       64'(ext_imm), 64'd0);
      rst_n = 1'b1;
      step();
      check("rel.in_ready",  64'(in_ready), 64'd1);
      check("rel.out_valid", 64'(out_valid), 64'd0);

      // ---- Streaming, no bubbles ----
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_instr = s_instr[i];
         step();
         check_word($sformatf("stream%0d", i), s_ctrl[i], s_src[i], s_imm[i], s_ov[i]);
         check($sformatf("stream%0d.in_ready", i), 64'(in_ready), 64'd1);
      end
      in_valid = 1'b0;
      step();
      check("stream.drain", 64'(out_valid), 64'd0);

      // ---- Immediates ----
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_instr = i_instr[i];
         step();
         in_valid = 1'b0;
         check_word($sformatf("imm%0d", i), i_ctrl[i], i_src[i], i_imm[i], i_ov[i]);
         step();
         check($sformatf("imm%0d.drain", i), 64'(out_valid), 64'd0);
      end

      // ---- Backpressure: A=add, B=ori, C=sub ----
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h00221820;
      step();
      check("bp.one.in_ready", 64'(in_ready), 64'd1);
      check("bp.one.ctrl",     64'(alu_ctrl), 64'(3'b100));
      in_instr = 32'h34221234;
      step();
      check("bp.two.in_ready", 64'(in_ready), 64'd0);
      check("bp.two.ctrl",     64'(alu_ctrl), 64'(3'b100));
      in_instr = 32'h00221822;
      step();
      check("bp.held.in_ready", 64'(in_ready), 64'd0);
      check("bp.held.valid",    64'(out_valid), 64'd1);
      check("bp.held.ctrl",     64'(alu_ctrl), 64'(3'b100));
      out_ready = 1'b1;
      step();
      check("bp.pop1.ctrl",     64'(alu_ctrl), 64'(3'b001));
      check("bp.pop1.imm",      64'(ext_imm), 64'h00001234);
      check("bp.pop1.in_ready", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      check("bp.pop2.ctrl", 64'(alu_ctrl), 64'(3'b110));
      check("bp.pop2.ov",   64'(ov_trap), 64'd1);
      step();
      check("bp.empty", 64'(out_valid), 64'd0);

      // ---- Flush from TWO with push offered ----
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h00221820;
      step();
      in_instr = 32'h34221234;
      step();
      check("fl.two.in_ready", 64'(in_ready), 64'd0);
      in_instr = 32'h00221822;
      flush    = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl.two.valid",    64'(out_valid), 64'd0);
      check("fl.two.in_ready", 64'(in_ready), 64'd1);
      step();
      check("fl.two.absent",   64'(out_valid), 64'd0);

      // ---- Flush from ONE drops a real push ----
      in_valid = 1'b1;
      in_instr = 32'h00221820;
      step();
      check("fl.one.valid", 64'(out_valid), 64'd1);
      in_instr = 32'h302200F0;
      flush    = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl.one.flushed", 64'(out_valid), 64'd0);
      step();
      check("fl.one.absent",  64'(out_valid), 64'd0);

      // ---- Reset mid-traffic ----
      in_valid = 1'b1;
      in_instr = 32'h34221234;
      step();
      in_instr = 32'h00221822;
      step();
      in_valid = 1'b0;
      check("mid.pre.ctrl", 64'(alu_ctrl), 64'(3'b001));
      #2 rst_n = 1'b0;
      #1;
      check("mid.rst.valid",    64'(out_valid), 64'd0);
      check("mid.rst.ctrl",     64'(alu_ctrl), 64'd0);
      check("mid.rst.in_ready", 64'(in_ready), 64'd0);
      step();
      rst_n = 1'b1;
      step();
      check("mid.rel.in_ready", 64'(in_ready), 64'd1);
      check("mid.rel.valid",    64'(out_valid), 64'd0);

      // ---- Illegal instruction ----
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = 32'hFC000000;
      step();
      in_valid = 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
      check("ill.valid", 64'(out_valid), 64'd1);
      check("ill.flag",  64'(illegal), 64'd1);
      check("ill.ctrl",  64'(alu_ctrl), 64'd0);
      check("ill.src",   64'(alu_src_imm), 64'd0);
      check("ill.ov",    64'(ov_trap), 64'd0);
`else
      check("ill.valid",    64'(out_valid), 64'd0);
      check("ill.flag",     64'(illegal), 64'd0);
      check("ill.in_ready", 64'(in_ready), 64'd1);
`endif
      $display("txn illegal: valid=%b illegal=%b", out_valid, illegal);
      step();
      check("ill.drain", 64'(out_valid), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
